// File: rtl/wb_forward_stage.sv
// ---------------------------------------------------------------------------
// wb_forward_stage
//
// Writeback stage of the 24-bit pipeline, directly upstream of the register
// file. Captures the MEM-stage result into the WB register (ALU/load select
// happens before the register), drives the register-file write port, and
// bypasses the in-flight WB result into the execute-stage operands.
//
// Optional feature macro: WB_RETIRE_CNT_EN
//   When defined, adds output retire_cnt, a 24-bit wrapping count of
//   instructions leaving WB (writing or not).
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid ... in_mem_data   result presented by the MEM stage
//   stall, flush        hold WB register / kill incoming result
//   in_ready            = ~stall
//   Rd, WriteD, RegWrite       register-file write port
//   ex_rs, ex_rt, ReadR1, ReadR2   execute-stage source indices and RF data
//   op_a, op_b          forwarded operands
//   fwd_a_hit, fwd_b_hit       operand taken from WB stage
//   retire_cnt          (WB_RETIRE_CNT_EN only) retired-instruction count
// ---------------------------------------------------------------------------
module wb_forward_stage #(
  parameter int DATA_W = 24,
  parameter int REG_AW = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              stall,
  input  logic              flush,
  output logic              in_ready,
  output logic [REG_AW-1:0] Rd,
  output logic [DATA_W-1:0] WriteD,
  output logic              RegWrite,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [DATA_W-1:0] ReadR1,
  input  logic [DATA_W-1:0] ReadR2,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              fwd_a_hit,
  output logic              fwd_b_hit
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [23:0]       retire_cnt
`endif
);

  logic              wb_valid_r;
  logic [REG_AW-1:0] wb_rd_r;
  logic              wb_reg_write_r;
  logic [DATA_W-1:0] wb_data_r;

  logic [DATA_W-1:0] in_sel_s;
  logic              wb_live_s;
  logic              fwd_a_s;
  logic              fwd_b_s;
  logic [DATA_W-1:0] op_a_s;
  logic [DATA_W-1:0] op_b_s;

  // Result select ahead of the WB register (one-cycle input-to-WriteD latency).
  always_comb begin
    in_sel_s = {DATA_W{1'b0}};
    if (in_mem_to_reg) begin
      in_sel_s = in_mem_data;
    end else begin
      in_sel_s = in_alu_result;
    end
  end

  // WB pipeline register; reset beats stall, and flush is ignored while stalled
  // so a held entry is never lost.
  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_r     <= 1'b0;
      wb_rd_r        <= {REG_AW{1'b0}};
      wb_reg_write_r <= 1'b0;
      wb_data_r      <= {DATA_W{1'b0}};
    end else if (!stall) begin
      wb_valid_r     <= in_valid & ~flush;
      wb_rd_r        <= in_rd;
      wb_reg_write_r <= in_reg_write;
      wb_data_r      <= in_sel_s;
    end else begin
      wb_valid_r     <= wb_valid_r;
      wb_rd_r        <= wb_rd_r;
      wb_reg_write_r <= wb_reg_write_r;
      wb_data_r      <= wb_data_r;
    end
  end

  // Only a valid, register-writing entry may write or forward. Forwarding stays
  // live under stall because the WB register still holds the newest value.
  always_comb begin
    wb_live_s = wb_valid_r & wb_reg_write_r;
    fwd_a_s   = 1'b0;
    fwd_b_s   = 1'b0;
    op_a_s    = ReadR1;
    op_b_s    = ReadR2;
    if (wb_live_s && (wb_rd_r == ex_rs)) begin
      fwd_a_s = 1'b1;
      op_a_s  = wb_data_r;
    end else begin
      fwd_a_s = 1'b0;
      op_a_s  = ReadR1;
    end
    if (wb_live_s && (wb_rd_r == ex_rt)) begin
      fwd_b_s = 1'b1;
      op_b_s  = wb_data_r;
    end else begin
      fwd_b_s = 1'b0;
      op_b_s  = ReadR2;
    end
  end

  // The write pulse is held off while stalled so each instruction writes once,
  // in the cycle it actually leaves WB.
  assign in_ready  = ~stall;
  assign Rd        = wb_rd_r;
  assign WriteD    = wb_data_r;
  assign RegWrite  = wb_live_s & ~stall;
  assign op_a      = op_a_s;
  assign op_b      = op_b_s;
  assign fwd_a_hit = fwd_a_s;
  assign fwd_b_hit = fwd_b_s;

`ifdef WB_RETIRE_CNT_EN
  logic [23:0] retire_cnt_r;

  // Count every instruction leaving WB, including non-writing ones; wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_cnt_r <= 24'd0;
    end else if (wb_valid_r && !stall) begin
      retire_cnt_r <= retire_cnt_r + 24'd1;
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  assign retire_cnt = retire_cnt_r;
`endif

endmodule

// File: tb/tb_wb_forward_stage.sv
module tb_wb_forward_stage;

  localparam int DATA_W = 24;
  localparam int REG_AW = 4;

  logic              clock;
  logic              reset;
  logic              in_valid;
  logic [REG_AW-1:0] in_rd;
  logic              in_reg_write;
  logic              in_mem_to_reg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_data;
  logic              stall;
  logic              flush;
  logic              in_ready;
  logic [REG_AW-1:0] Rd;
  logic [DATA_W-1:0] WriteD;
  logic              RegWrite;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [DATA_W-1:0] ReadR1;
  logic [DATA_W-1:0] ReadR2;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              fwd_a_hit;
  logic              fwd_b_hit;
`ifdef WB_RETIRE_CNT_EN
  logic [23:0]       retire_cnt;
`endif

  int vectors;
  int miscompares;

  wb_forward_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_rd(in_rd),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .stall(stall), .flush(flush), .in_ready(in_ready), .Rd(Rd),
    .WriteD(WriteD), .RegWrite(RegWrite), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ReadR1(ReadR1), .ReadR2(ReadR2), .op_a(op_a), .op_b(op_b),
    .fwd_a_hit(fwd_a_hit), .fwd_b_hit(fwd_b_hit)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change just after the falling edge; the DUT captures on the rising edge.
  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    reset = 1'b0; in_valid = 1'b0; in_rd = 4'd0; in_reg_write = 1'b0;
    in_mem_to_reg = 1'b0; in_alu_result = 24'd0; in_mem_data = 24'd0;
    stall = 1'b0; flush = 1'b0; ex_rs = 4'd0; ex_rt = 4'd0;
    ReadR1 = 24'd0; ReadR2 = 24'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0; ex_rs = 4'd0; ex_rt = 4'd0; ReadR1 = 24'h5A5A5A; ReadR2 = 24'hA5A5A5;
    #1;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL reset_regwrite: got %0h expected 0", RegWrite); end
    vectors++; if (WriteD !== 24'd0) begin miscompares++; $display("FAIL reset_writed: got %0h expected 0", WriteD); end
    vectors++; if (Rd !== 4'd0) begin miscompares++; $display("FAIL reset_rd: got %0h expected 0", Rd); end
    vectors++; if (fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hits: got %0b%0b expected 00", fwd_a_hit, fwd_b_hit); end
    vectors++; if (op_a !== 24'h5A5A5A || op_b !== 24'hA5A5A5) begin miscompares++; $display("FAIL reset_passthru: got %0h/%0h expected 5a5a5a/a5a5a5", op_a, op_b); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0h expected 1", in_ready); end
  endtask

  task automatic test_alu_writeback();
    idle_inputs();
    in_valid = 1'b1; in_rd = 4'd3; in_reg_write = 1'b1; in_mem_to_reg = 1'b0;
    in_alu_result = 24'h00ABCD; in_mem_data = 24'hFFFFFF;
    next_cycle();
    idle_inputs();
    #1;
    vectors++; if (RegWrite !== 1'b1 || Rd !== 4'd3 || WriteD !== 24'h00ABCD) begin miscompares++; $display("FAIL alu_wb: got we=%0h rd=%0h d=%0h expected we=1 rd=3 d=00abcd", RegWrite, Rd, WriteD); end
    next_cycle();
    #1;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL alu_wb_single_pulse: got %0h expected 0", RegWrite); end
  endtask

  task automatic test_load_forward();
    idle_inputs();
    in_valid = 1'b1; in_rd = 4'd5; in_reg_write = 1'b1; in_mem_to_reg = 1'b1;
    in_mem_data = 24'h123456; in_alu_result = 24'h654321;
    next_cycle();
    idle_inputs();
    ex_rs = 4'd5; ex_rt = 4'd5; ReadR1 = 24'd0; ReadR2 = 24'd0;
    #1;
    vectors++; if (op_a !== 24'h123456 || op_b !== 24'h123456) begin miscompares++; $display("FAIL load_fwd_ops: got %0h/%0h expected 123456/123456", op_a, op_b); end
    vectors++; if (fwd_a_hit !== 1'b1 || fwd_b_hit !== 1'b1) begin miscompares++; $display("FAIL load_fwd_hits: got %0b%0b expected 11", fwd_a_hit, fwd_b_hit); end
    ex_rt = 4'd6; ReadR2 = 24'h0000AA;
    #1;
    vectors++; if (fwd_b_hit !== 1'b0 || op_b !== 24'h0000AA) begin miscompares++; $display("FAIL load_fwd_miss_b: got hit=%0b op=%0h expected hit=0 op=0000aa", fwd_b_hit, op_b); end
    next_cycle();
  endtask

  task automatic test_stall();
    idle_inputs();
    in_valid = 1'b1; in_rd = 4'd7; in_reg_write = 1'b1; in_alu_result = 24'h777111;
    next_cycle();
    // A new result and a flush arrive while stalled: neither may disturb the held entry.
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1; in_rd = 4'd9; in_alu_result = 24'h999999;
    ex_rs = 4'd7; ReadR1 = 24'h0F0F0F;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (RegWrite !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hold_we: got we=%0h rdy=%0h expected 0/0", RegWrite, in_ready); end
      vectors++; if (op_a !== 24'h777111 || fwd_a_hit !== 1'b1 || Rd !== 4'd7) begin miscompares++; $display("FAIL stall_fwd: got op=%0h hit=%0b rd=%0h expected 777111/1/7", op_a, fwd_a_hit, Rd); end
      next_cycle();
    end
    idle_inputs();
    #1;
    vectors++; if (RegWrite !== 1'b1 || WriteD !== 24'h777111 || Rd !== 4'd7) begin miscompares++; $display("FAIL stall_release: got we=%0h d=%0h rd=%0h expected 1/777111/7", RegWrite, WriteD, Rd); end
    next_cycle();
    #1;
    vectors++; if (RegWrite !== 1'b0) begin miscompares++; $display("FAIL stall_single_pulse: got %0h expected 0", RegWrite); end
  endtask

  task automatic test_flush();
    idle_inputs();
    in_valid = 1'b1; flush = 1'b1; in_rd = 4'd2; in_reg_write = 1'b1; in_alu_result = 24'h222222;
    next_cycle();
    idle_inputs();
    ex_rs = 4'd2; ReadR1 = 24'h0BEEF0;
    #1;
    vectors++; if (RegWrite !== 1'b0 || fwd_a_hit !== 1'b0 || op_a !== 24'h0BEEF0) begin miscompares++; $display("FAIL flush: got we=%0h hit=%0b op=%0h expected 0/0/0beef0", RegWrite, fwd_a_hit, op_a); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    in_valid = 1'b1; in_rd = 4'd0; in_reg_write = 1'b1; in_alu_result = 24'hC0FFEE;
    next_cycle();
    idle_inputs();
    ex_rs = 4'd0; ex_rt = 4'd0; ReadR1 = 24'h111111; ReadR2 = 24'h222222;
    #1;
    vectors++; if (fwd_a_hit !== 1'b1 || op_a !== 24'hC0FFEE) begin miscompares++; $display("FAIL reg0_fwd: got hit=%0b op=%0h expected 1/c0ffee", fwd_a_hit, op_a); end
    reset = 1'b1; stall = 1'b1;
    next_cycle();
    reset = 1'b0; stall = 1'b0;
    #1;
    vectors++; if (RegWrite !== 1'b0 || WriteD !== 24'd0 || fwd_a_hit !== 1'b0 || fwd_b_hit !== 1'b0) begin miscompares++; $display("FAIL reset_mid: got we=%0h d=%0h hits=%0b%0b expected 0/0/00", RegWrite, WriteD, fwd_a_hit, fwd_b_hit); end
    vectors++; if (op_a !== 24'h111111 || op_b !== 24'h222222) begin miscompares++; $display("FAIL reset_mid_passthru: got %0h/%0h expected 111111/222222", op_a, op_b); end
`ifdef WB_RETIRE_CNT_EN
    vectors++; if (retire_cnt !== 24'd0) begin miscompares++; $display("FAIL reset_mid_cnt: got %0h expected 0", retire_cnt); end
`endif
  endtask

  // Reference: the instruction currently in WB is whatever was last accepted
  // (not stalled) unless it was flushed; a write happens when it leaves.
  task automatic test_random();
    bit              m_valid = 1'b0;
    bit              m_we    = 1'b0;
    bit [3:0]        m_rd    = 4'd0;
    bit [23:0]       m_data  = 24'd0;
    int unsigned     m_retired = 0;
    int unsigned     writes_seen = 0;
    int unsigned     writes_expected = 0;
    bit              exp_we;
    bit              exp_ha;
    bit              exp_hb;
    bit [23:0]       exp_a;
    bit [23:0]       exp_b;
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 39) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_rd         = 4'($urandom_range(0, 3));
      in_reg_write  = ($urandom_range(0, 4) != 0);
      in_mem_to_reg = 1'($urandom_range(0, 1));
      in_alu_result = 24'($urandom);
      in_mem_data   = 24'($urandom);
      stall         = ($urandom_range(0, 3) == 0);
      flush         = ($urandom_range(0, 5) == 0);
      ex_rs         = 4'($urandom_range(0, 3));
      ex_rt         = 4'($urandom_range(0, 3));
      ReadR1        = 24'($urandom);
      ReadR2        = 24'($urandom);
      #1;
      exp_we = m_valid && m_we && !stall;
      exp_ha = m_valid && m_we && (m_rd == ex_rs);
      exp_hb = m_valid && m_we && (m_rd == ex_rt);
      exp_a  = exp_ha ? m_data : ReadR1;
      exp_b  = exp_hb ? m_data : ReadR2;
      vectors++; if (RegWrite !== exp_we) begin miscompares++; $display("FAIL rnd_we[%0d]: got %0h expected %0h", n, RegWrite, exp_we); end
      vectors++; if (Rd !== m_rd || WriteD !== m_data) begin miscompares++; $display("FAIL rnd_port[%0d]: got rd=%0h d=%0h expected rd=%0h d=%0h", n, Rd, WriteD, m_rd, m_data); end
      vectors++; if (fwd_a_hit !== exp_ha || op_a !== exp_a) begin miscompares++; $display("FAIL rnd_a[%0d]: got hit=%0b op=%0h expected hit=%0b op=%0h", n, fwd_a_hit, op_a, exp_ha, exp_a); end
      vectors++; if (fwd_b_hit !== exp_hb || op_b !== exp_b) begin miscompares++; $display("FAIL rnd_b[%0d]: got hit=%0b op=%0h expected hit=%0b op=%0h", n, fwd_b_hit, op_b, exp_hb, exp_b); end
`ifdef WB_RETIRE_CNT_EN
      vectors++; if (retire_cnt !== 24'(m_retired)) begin miscompares++; $display("FAIL rnd_cnt[%0d]: got %0h expected %0h", n, retire_cnt, 24'(m_retired)); end
`endif
      if (RegWrite === 1'b1) writes_seen++;
      if (exp_we) writes_expected++;
      if (reset) begin
        m_valid = 1'b0; m_we = 1'b0; m_rd = 4'd0; m_data = 24'd0; m_retired = 0;
      end else if (!stall) begin
        if (m_valid) m_retired++;
        m_valid = in_valid && !flush;
        m_we    = in_reg_write;
        m_rd    = in_rd;
        m_data  = in_mem_to_reg ? in_mem_data : in_alu_result;
      end
      next_cycle();
    end
    vectors++; if (writes_seen != writes_expected) begin miscompares++; $display("FAIL rnd_write_total: got %0d expected %0d", writes_seen, writes_expected); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_alu_writeback();
    test_load_forward();
    test_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
